// File: rtl/id_ex_register.sv
// -----------------------------------------------------------------------------
// id_ex_register
// Pipeline register between the decode (ID) and execute (EX) stages of a
// RISC-V style core. Captures decoded control and operand fields on each
// rising clock edge.
//
// Edge priority: flush > stall > load. A flush, or a load of an invalid
// decode slot, inserts a bubble: every field is cleared, so an invalid slot
// never carries RegWrite/MemRead/MemWrite/Branch into EX.
//
// Optional feature macro: ID_EX_PERF_CNT_EN
//   defined   -> 16-bit saturating stall/flush performance counters
//   undefined -> no counter flops; stall_cnt/flush_cnt tied to 16'h0000
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   stall, flush          hold contents / replace with bubble
//   id_valid ... id_rd    decode-stage fields (ctrl = {RegWrite, MemRead,
//                         MemWrite, Branch, ALUSrc, MemtoReg})
//   ex_valid ... ex_rd    registered copies driven straight from flops
//   stall_cnt, flush_cnt  performance counters
// -----------------------------------------------------------------------------
module id_ex_register #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [1:0]        id_ALUOp,
    input  logic [2:0]        id_Funct3,
    input  logic [6:0]        id_Funct7,
    input  logic [5:0]        id_ctrl,
    input  logic [DATA_W-1:0] id_rs1_data,
    input  logic [DATA_W-1:0] id_rs2_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [DATA_W-1:0] id_pc,
    input  logic [4:0]        id_rd,
    output logic              ex_valid,
    output logic [1:0]        ex_ALUOp,
    output logic [2:0]        ex_Funct3,
    output logic [6:0]        ex_Funct7,
    output logic [5:0]        ex_ctrl,
    output logic [DATA_W-1:0] ex_rs1_data,
    output logic [DATA_W-1:0] ex_rs2_data,
    output logic [DATA_W-1:0] ex_imm,
    output logic [DATA_W-1:0] ex_pc,
    output logic [4:0]        ex_rd,
    output logic [15:0]       stall_cnt,
    output logic [15:0]       flush_cnt
);

    // The state bit itself is ex_valid, so ex_valid comes straight off a flop.
    typedef enum logic [0:0] {
        ST_BUBBLE = 1'b0,
        ST_LOADED = 1'b1
    } state_t;

    state_t             state_r,   state_s;
    logic [1:0]         alu_op_r,  alu_op_s;
    logic [2:0]         funct3_r,  funct3_s;
    logic [6:0]         funct7_r,  funct7_s;
    logic [5:0]         ctrl_r,    ctrl_s;
    logic [DATA_W-1:0]  rs1_r,     rs1_s;
    logic [DATA_W-1:0]  rs2_r,     rs2_s;
    logic [DATA_W-1:0]  imm_r,     imm_s;
    logic [DATA_W-1:0]  pc_r,      pc_s;
    logic [4:0]         rd_r,      rd_s;

    // Next-state and next-contents selection: flush > stall > load.
    always_comb begin
        state_s  = state_r;
        alu_op_s = alu_op_r;
        funct3_s = funct3_r;
        funct7_s = funct7_r;
        ctrl_s   = ctrl_r;
        rs1_s    = rs1_r;
        rs2_s    = rs2_r;
        imm_s    = imm_r;
        pc_s     = pc_r;
        rd_s     = rd_r;
        if (flush || (!stall && !id_valid)) begin
            // Bubble: squashed or invalid slot, every field cleared.
            state_s  = ST_BUBBLE;
            alu_op_s = 2'b00;
            funct3_s = 3'b000;
            funct7_s = 7'b0000000;
            ctrl_s   = 6'b000000;
            rs1_s    = {DATA_W{1'b0}};
            rs2_s    = {DATA_W{1'b0}};
            imm_s    = {DATA_W{1'b0}};
            pc_s     = {DATA_W{1'b0}};
            rd_s     = 5'd0;
        end else if (stall) begin
            // EX not ready: keep state and contents.
            state_s  = state_r;
        end else begin
            // Normal load of a real instruction.
            state_s  = ST_LOADED;
            alu_op_s = id_ALUOp;
            funct3_s = id_Funct3;
            funct7_s = id_Funct7;
            ctrl_s   = id_ctrl;
            rs1_s    = id_rs1_data;
            rs2_s    = id_rs2_data;
            imm_s    = id_imm;
            pc_s     = id_pc;
            rd_s     = id_rd;
        end
    end

    // Pipeline register with asynchronous clear to the bubble state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r  <= ST_BUBBLE;
            alu_op_r <= 2'b00;
            funct3_r <= 3'b000;
            funct7_r <= 7'b0000000;
            ctrl_r   <= 6'b000000;
            rs1_r    <= {DATA_W{1'b0}};
            rs2_r    <= {DATA_W{1'b0}};
            imm_r    <= {DATA_W{1'b0}};
            pc_r     <= {DATA_W{1'b0}};
            rd_r     <= 5'd0;
        end else begin
            state_r  <= state_s;
            alu_op_r <= alu_op_s;
            funct3_r <= funct3_s;
            funct7_r <= funct7_s;
            ctrl_r   <= ctrl_s;
            rs1_r    <= rs1_s;
            rs2_r    <= rs2_s;
            imm_r    <= imm_s;
            pc_r     <= pc_s;
            rd_r     <= rd_s;
        end
    end

    assign ex_valid    = state_r;
    assign ex_ALUOp    = alu_op_r;
    assign ex_Funct3   = funct3_r;
    assign ex_Funct7   = funct7_r;
    assign ex_ctrl     = ctrl_r;
    assign ex_rs1_data = rs1_r;
    assign ex_rs2_data = rs2_r;
    assign ex_imm      = imm_r;
    assign ex_pc       = pc_r;
    assign ex_rd       = rd_r;

`ifdef ID_EX_PERF_CNT_EN
    logic [15:0] stall_cnt_r, stall_cnt_s;
    logic [15:0] flush_cnt_r, flush_cnt_s;

    // Saturating increment: sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc(input logic [15:0] value);
        if (value == 16'hFFFF) begin
            return value;
        end else begin
            return value + 16'd1;
        end
    endfunction

    // Counter events are qualified by the current ex_valid: only stalls
    // holding, and flushes squashing, a real instruction are counted.
    always_comb begin
        stall_cnt_s = stall_cnt_r;
        flush_cnt_s = flush_cnt_r;
        if (stall && !flush && (state_r == ST_LOADED)) begin
            stall_cnt_s = sat_inc(stall_cnt_r);
        end else begin
            stall_cnt_s = stall_cnt_r;
        end
        if (flush && (state_r == ST_LOADED)) begin
            flush_cnt_s = sat_inc(flush_cnt_r);
        end else begin
            flush_cnt_s = flush_cnt_r;
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_r <= 16'h0000;
            flush_cnt_r <= 16'h0000;
        end else begin
            stall_cnt_r <= stall_cnt_s;
            flush_cnt_r <= flush_cnt_s;
        end
    end

    assign stall_cnt = stall_cnt_r;
    assign flush_cnt = flush_cnt_r;
`else
    assign stall_cnt = 16'h0000;
    assign flush_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_id_ex_register.sv
// -----------------------------------------------------------------------------
// tb_id_ex_register
// Self-checking bench for id_ex_register (DATA_W = 32). A table of directed
// vectors {stall, flush, id fields, expected ex fields, expected counters} is
// applied one clock edge per entry, followed by hand-written sequences for
// asynchronous reset and counter saturation. Expected counter values assume
// ID_EX_PERF_CNT_EN; without it the counters are expected to read zero.
// -----------------------------------------------------------------------------
module tb_id_ex_register;

    typedef struct packed {
        logic        valid;
        logic [1:0]  aluop;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [5:0]  ctrl;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [4:0]  rd;
    } fields_t;

    typedef struct packed {
        logic        stall;
        logic        flush;
        fields_t     id;
        fields_t     ex;
        logic [15:0] scnt;
        logic [15:0] fcnt;
    } vec_t;

    localparam int NVEC = 13;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        flush;
    fields_t     id_f;
    logic        ex_valid;
    logic [1:0]  ex_ALUOp;
    logic [2:0]  ex_Funct3;
    logic [6:0]  ex_Funct7;
    logic [5:0]  ex_ctrl;
    logic [31:0] ex_rs1_data, ex_rs2_data, ex_imm, ex_pc;
    logic [4:0]  ex_rd;
    logic [15:0] stall_cnt, flush_cnt;
    fields_t     act;

    int tests_run = 0;
    int tests_failed = 0;

    vec_t    vecs [NVEC];
    fields_t bub, sub_f, oth_f, addi_f, inv_f, lw_f, beq_f, jal_f;

    id_ex_register #(.DATA_W(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .flush       (flush),
        .id_valid    (id_f.valid),
        .id_ALUOp    (id_f.aluop),
        .id_Funct3   (id_f.f3),
        .id_Funct7   (id_f.f7),
        .id_ctrl     (id_f.ctrl),
        .id_rs1_data (id_f.rs1),
        .id_rs2_data (id_f.rs2),
        .id_imm      (id_f.imm),
        .id_pc       (id_f.pc),
        .id_rd       (id_f.rd),
        .ex_valid    (ex_valid),
        .ex_ALUOp    (ex_ALUOp),
        .ex_Funct3   (ex_Funct3),
        .ex_Funct7   (ex_Funct7),
        .ex_ctrl     (ex_ctrl),
        .ex_rs1_data (ex_rs1_data),
        .ex_rs2_data (ex_rs2_data),
        .ex_imm      (ex_imm),
        .ex_pc       (ex_pc),
        .ex_rd       (ex_rd),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
    );

    assign act = {ex_valid, ex_ALUOp, ex_Funct3, ex_Funct7, ex_ctrl,
                  ex_rs1_data, ex_rs2_data, ex_imm, ex_pc, ex_rd};

    // 100 MHz-style free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic fields_t mk(input logic v, input logic [1:0] a,
                                   input logic [2:0] f3, input logic [6:0] f7,
                                   input logic [5:0] c, input logic [31:0] r1,
                                   input logic [31:0] r2, input logic [31:0] im,
                                   input logic [31:0] pc, input logic [4:0] rd);
        fields_t f;
        f = {v, a, f3, f7, c, r1, r2, im, pc, rd};
        return f;
    endfunction

    function automatic vec_t mkv(input logic s, input logic f, input fields_t id,
                                 input fields_t ex, input logic [15:0] sc,
                                 input logic [15:0] fc);
        vec_t v;
        v = {s, f, id, ex, sc, fc};
        return v;
    endfunction

    task automatic check(input string name, input logic [159:0] actual,
                         input logic [159:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic check_fields(input string tag, input fields_t exp);
        check({tag, ".valid"}, {159'd0, act.valid}, {159'd0, exp.valid});
        check({tag, ".ctrl"},  {154'd0, act.ctrl},  {154'd0, exp.ctrl});
        check({tag, ".alu"},   {148'd0, act.aluop, act.f3, act.f7},
                               {148'd0, exp.aluop, exp.f3, exp.f7});
        check({tag, ".data"},  {27'd0, act.rs1, act.rs2, act.imm, act.pc, act.rd},
                               {27'd0, exp.rs1, exp.rs2, exp.imm, exp.pc, exp.rd});
    endtask

    task automatic check_cnt(input string tag, input logic [15:0] sc,
                             input logic [15:0] fc);
        logic [15:0] es, ef;
`ifdef ID_EX_PERF_CNT_EN
        es = sc;
        ef = fc;
`else
        es = 16'h0000 & sc;
        ef = 16'h0000 & fc;
`endif
        check({tag, ".stall_cnt"}, {144'd0, stall_cnt}, {144'd0, es});
        check({tag, ".flush_cnt"}, {144'd0, flush_cnt}, {144'd0, ef});
    endtask

    task automatic drive(input logic s, input logic f, input fields_t id);
        stall = s;
        flush = f;
        id_f  = id;
    endtask

    // One active edge, then settle away from it before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bub    = '0;
        sub_f  = mk(1'b1, 2'b10, 3'b000, 7'b0100000, 6'b100000, 32'd5, 32'd3,
                    32'd0, 32'h0000_0100, 5'd7);
        oth_f  = mk(1'b1, 2'b00, 3'b010, 7'b0000000, 6'b110011, 32'hAAAA_5555,
                    32'h1234_5678, 32'd8, 32'h0000_0300, 5'd31);
        addi_f = mk(1'b1, 2'b10, 3'b000, 7'b0000000, 6'b100010, 32'd10, 32'd0,
                    32'hFFFF_FFFC, 32'h0000_0104, 5'd9);
        inv_f  = mk(1'b0, 2'b10, 3'b111, 7'b1111111, 6'b111111, 32'd1, 32'd2,
                    32'd3, 32'd4, 5'd3);
        lw_f   = mk(1'b1, 2'b00, 3'b010, 7'b0000000, 6'b110011, 32'h0000_1000,
                    32'd0, 32'd8, 32'h0000_0108, 5'd5);
        beq_f  = mk(1'b1, 2'b01, 3'b000, 7'b0000000, 6'b000100, 32'd4, 32'd4,
                    32'd16, 32'h0000_010C, 5'd0);
        jal_f  = mk(1'b1, 2'b11, 3'b000, 7'b0000000, 6'b100000, 32'd0, 32'd0,
                    32'h0000_0040, 32'h0000_0200, 5'd1);

        //                stall flush  id      expected ex  scnt fcnt
        vecs[0]  = mkv(1'b0, 1'b0, sub_f,  sub_f,  16'd0, 16'd0); // SUB load
        vecs[1]  = mkv(1'b1, 1'b0, oth_f,  sub_f,  16'd1, 16'd0); // stall 1
        vecs[2]  = mkv(1'b1, 1'b0, oth_f,  sub_f,  16'd2, 16'd0); // stall 2
        vecs[3]  = mkv(1'b1, 1'b0, inv_f,  sub_f,  16'd3, 16'd0); // stall 3
        vecs[4]  = mkv(1'b0, 1'b0, addi_f, addi_f, 16'd3, 16'd0); // ADDI load
        vecs[5]  = mkv(1'b1, 1'b1, oth_f,  bub,    16'd3, 16'd1); // flush beats stall
        vecs[6]  = mkv(1'b1, 1'b0, lw_f,   bub,    16'd3, 16'd1); // stall on bubble
        vecs[7]  = mkv(1'b0, 1'b0, inv_f,  bub,    16'd3, 16'd1); // invalid load
        vecs[8]  = mkv(1'b0, 1'b0, lw_f,   lw_f,   16'd3, 16'd1); // LW load
        vecs[9]  = mkv(1'b0, 1'b0, beq_f,  beq_f,  16'd3, 16'd1); // BEQ load
        vecs[10] = mkv(1'b0, 1'b1, jal_f,  bub,    16'd3, 16'd2); // flush real instr
        vecs[11] = mkv(1'b0, 1'b1, jal_f,  bub,    16'd3, 16'd2); // flush bubble
        vecs[12] = mkv(1'b0, 1'b0, jal_f,  jal_f,  16'd3, 16'd2); // JAL load

        drive(1'b0, 1'b0, sub_f);
        reset = 1'b1;
        #3;
        check_fields("reset", bub);
        check_cnt("reset", 16'd0, 16'd0);
        step();
        reset = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].stall, vecs[i].flush, vecs[i].id);
            step();
            check_fields($sformatf("vec%0d", i), vecs[i].ex);
            check_cnt($sformatf("vec%0d", i), vecs[i].scnt, vecs[i].fcnt);
        end

        // Asynchronous reset between edges while LOADED (JAL held).
        drive(1'b0, 1'b0, sub_f);
        #2;
        reset = 1'b1;
        #1;
        check_fields("async_reset", bub);
        check_cnt("async_reset", 16'd0, 16'd0);

        // Reset held through an edge with stall and flush both asserted.
        drive(1'b1, 1'b1, sub_f);
        step();
        check_fields("reset_over_flush", bub);
        check_cnt("reset_over_flush", 16'd0, 16'd0);

        // Release: first edge afterwards is an ordinary load.
        reset = 1'b0;
        drive(1'b0, 1'b0, sub_f);
        step();
        check_fields("post_reset_load", sub_f);
        check_cnt("post_reset_load", 16'd0, 16'd0);

        // Long stall up to 16'hFFFE, then three more edges to saturate.
        drive(1'b1, 1'b0, oth_f);
        for (int i = 0; i < 65534; i++) begin
            step();
        end
        check_fields("long_stall", sub_f);
        check_cnt("preload", 16'hFFFE, 16'd0);
        for (int i = 0; i < 3; i++) begin
            step();
        end
        check_fields("sat_hold", sub_f);
        check_cnt("saturate", 16'hFFFF, 16'd0);

        // Flush after saturation: flush count moves, stall count stays pinned.
        drive(1'b1, 1'b1, oth_f);
        step();
        check_fields("sat_flush", bub);
        check_cnt("sat_flush", 16'hFFFF, 16'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/id_ex_register.md
ID_EX_REGISTER -- requirements
Module: id_ex_register

Interface
REQ-001 Parameter DATA_W, default 32, datapath width of operand, immediate and PC fields.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 stall  input  1  hold current contents (EX not ready).
REQ-005 flush  input  1  replace next contents with a bubble (branch taken / load-use).
REQ-006 id_valid  input  1  decode stage presents a real instruction.
REQ-007 id_ALUOp  input  2  00 LW/SW/AUIPC, 01 branch, 10 R/I-type, 11 JAL/LUI.
REQ-008 id_Funct3  input  3  instruction bits 14:12.
REQ-009 id_Funct7  input  7  instruction bits 31:25.
REQ-010 id_ctrl  input  6  {RegWrite, MemRead, MemWrite, Branch, ALUSrc, MemtoReg}.
REQ-011 id_rs1_data, id_rs2_data, id_imm, id_pc  input  DATA_W each  operands, immediate, PC.
REQ-012 id_rd  input  5  destination register index.
REQ-013 ex_valid, ex_ALUOp, ex_Funct3, ex_Funct7, ex_ctrl, ex_rs1_data, ex_rs2_data, ex_imm, ex_pc, ex_rd  output  same widths as id_* counterparts  registered copies feeding the ALU controller and ALU.
REQ-014 stall_cnt, flush_cnt  output  16 each  performance counters (see Configuration).

Function
REQ-015 Every ex_* output SHALL be driven directly from a flop; no combinational path from any input to any ex_* output.
REQ-016 Latency SHALL be one cycle: id_* sampled at edge N appear on ex_* after edge N.
REQ-017 Priority per edge SHALL be flush > stall > load.
REQ-018 Load: all ex_* SHALL take the id_* values; ex_valid SHALL equal id_valid.
REQ-019 Stall without flush: all ex_* SHALL hold their values, for any number of consecutive cycles.
REQ-020 Flush (stall is ignored): ex_valid=0, ex_ctrl=6'b0, ex_ALUOp=2'b00, ex_Funct3=3'b000, ex_Funct7=7'b0; data fields, ex_rd and ex_pc SHALL be cleared to 0.
REQ-021 Load with id_valid=0 SHALL produce the same bubble as REQ-020, so an invalid slot never carries RegWrite, MemRead, MemWrite or Branch.
REQ-022 The block SHALL have two states: LOADED (ex_valid=1) and BUBBLE (ex_valid=0). Transitions: load with id_valid=1 goes to LOADED; flush or a load with id_valid=0 goes to BUBBLE; stall keeps the current state.
REQ-023 stall_cnt SHALL increment on each edge where stall=1, flush=0 and ex_valid=1; it saturates at 16'hFFFF.
REQ-024 flush_cnt SHALL increment on each edge where flush=1 and ex_valid=1 (a real instruction is squashed); it saturates at 16'hFFFF.

Reset
REQ-025 Reset assertion SHALL immediately, independent of clk, force every ex_* output, stall_cnt and flush_cnt to 0 (BUBBLE state).
REQ-026 A reset asserted mid-stall or mid-flush SHALL override both; the first edge after deassertion performs a normal flush/stall/load evaluation.

Configuration
REQ-027 Macro ID_EX_PERF_CNT_EN defined: the counters are implemented per REQ-023/024.
REQ-028 Macro ID_EX_PERF_CNT_EN undefined: no counter flops exist and stall_cnt and flush_cnt SHALL be tied to 16'h0000; all other behaviour SHALL be identical.

Verification
REQ-029 Load: id_valid=1, id_ALUOp=10, id_Funct3=000, id_Funct7=0100000, id_rs1_data=5, id_rs2_data=3, then one edge -> ex_* match (SUB fields), ex_valid=1.
REQ-030 Stall: load as in REQ-029, then present different id_* with stall=1 for 3 edges -> ex_* unchanged; stall_cnt=3 (macro on).
REQ-031 Flush beats stall: ex_valid=1, stall=1 and flush=1 for one edge -> ex_valid=0, ex_ctrl=0, ex_ALUOp=00; flush_cnt=1, stall_cnt not incremented.
REQ-032 Invalid load: id_valid=0 with id_ctrl=6'b111111 -> ex_ctrl=0, ex_valid=0.
REQ-033 Async reset: assert reset between clock edges while LOADED -> all outputs 0 before the next edge.
REQ-034 Saturation: preload stall_cnt to 16'hFFFE and stall for 3 edges -> stall_cnt=16'hFFFF; with the macro undefined, the counters read 0 throughout.
